vin_timing_mon: RTL and testbench



---
 rtl/vin_timing_mon.sv | 218 +++++++++++++++++++++
 tb/tb_vin_timing_mon.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vin_timing_mon.sv
// Video timing monitor: one-cycle passthrough of the pixel stream with pixel coordinates,
// per-frame timing checks against nominal parameters and a lock state machine.
module vin_timing_mon #(
  parameter int H_WIDTH     = 1920,
  parameter int H_START     = 2008,
  parameter int H_TOTAL     = 2200,
  parameter int V_HEIGHT    = 1080,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 8388608
) (
  input  logic        vin_clk_i,
  input  logic        vin_rst_i,
  input  logic        vin_hs_i,
  input  logic        vin_vs_i,
  input  logic        vin_de_i,
  input  logic [23:0] vin_data_i,
  output logic        vout_hs_o,
  output logic        vout_vs_o,
  output logic        vout_de_o,
  output logic [23:0] vout_data_o,
  output logic [11:0] h_cnt_o,
  output logic [10:0] v_cnt_o,
  output logic        frame_o,
  output logic        locked_o,
  output logic [2:0]  err_o
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic [12:0] H_WIDTH_C  = 13'(H_WIDTH);
  localparam logic [12:0] H_START_C  = 13'(H_START);
  localparam logic [12:0] H_TOTAL_C  = 13'(H_TOTAL);
  localparam logic [11:0] V_HEIGHT_C = 12'(V_HEIGHT);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
  localparam logic [23:0] TIMEOUT_C  = 24'(TIMEOUT);

  logic        hs_q, vs_q, de_q;
  logic [23:0] data_q;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        line_seen_q, line_seen_d;
  logic        hs_pend_q, hs_pend_d;
  logic        h_acc_q, h_acc_d;
  logic        hs_acc_q, hs_acc_d;
  logic        frame_q, frame_d;
  logic        locked_q, locked_d;
  logic [2:0]  err_q, err_d;
  state_e      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [23:0] to_cnt_q, to_cnt_d;

  logic        de_rise_s, de_fall_s, hs_rise_s, vs_rise_s;
  logic        line_seen_eff_s;
  logic [12:0] h_inc_s;
  logic [11:0] v_inc_s;
  logic        h_now_s, hs_now_s;
  logic [2:0]  flags_s;
  logic        good_s, timeout_s;

  // Next-state logic: edges, counters, line checks, frame evaluation and lock FSM
  always_comb begin
    de_rise_s = vin_de_i & ~de_q;
    de_fall_s = ~vin_de_i & de_q;
    hs_rise_s = vin_hs_i & ~hs_q;
    vs_rise_s = vin_vs_i & ~vs_q;
    h_inc_s   = {1'b0, h_cnt_q} + 13'd1;
    v_inc_s   = {1'b0, v_cnt_q} + 12'd1;
    // A DE rise coinciding with VS rise opens line 0 of the new frame.
    line_seen_eff_s = line_seen_q & ~vs_rise_s;

    h_now_s   = (de_rise_s & line_seen_eff_s & (h_inc_s != H_TOTAL_C)) |
                (de_fall_s & (h_inc_s != H_WIDTH_C));
    hs_now_s  = hs_rise_s & hs_pend_q & (h_inc_s != H_START_C);
    flags_s   = {hs_acc_q | hs_now_s, h_acc_q | h_now_s,
                 ~line_seen_q | (v_inc_s != V_HEIGHT_C)};
    good_s    = (flags_s == 3'b000);
    timeout_s = (to_cnt_q >= TIMEOUT_C);

    if (de_rise_s) begin
      h_cnt_d = 12'd0;
    end else if (h_cnt_q == 12'hFFF) begin
      h_cnt_d = h_cnt_q;
    end else begin
      h_cnt_d = h_cnt_q + 12'd1;
    end

    if (de_rise_s && line_seen_eff_s) begin
      v_cnt_d = (v_cnt_q == 11'h7FF) ? v_cnt_q : v_cnt_q + 11'd1;
    end else if (de_rise_s) begin
      v_cnt_d = 11'd0;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    if (de_rise_s) begin
      line_seen_d = 1'b1;
    end else if (vs_rise_s) begin
      line_seen_d = 1'b0;
    end else begin
      line_seen_d = line_seen_q;
    end

    if (de_rise_s) begin
      hs_pend_d = 1'b1;
    end else if (hs_rise_s) begin
      hs_pend_d = 1'b0;
    end else begin
      hs_pend_d = hs_pend_q;
    end

    if (vs_rise_s) begin
      h_acc_d  = 1'b0;
      hs_acc_d = 1'b0;
      to_cnt_d = 24'd0;
    end else begin
      h_acc_d  = h_acc_q | h_now_s;
      hs_acc_d = hs_acc_q | hs_now_s;
      to_cnt_d = (to_cnt_q == 24'hFFFFFF) ? to_cnt_q : to_cnt_q + 24'd1;
    end

    frame_d    = vs_rise_s;
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = err_q;
    if (vs_rise_s) begin
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_MEASURE;
          good_cnt_d = 4'd0;
        end
        ST_MEASURE: begin
          err_d = flags_s;
          if (!good_s) begin
            good_cnt_d = 4'd0;
          end else if ((good_cnt_q + 4'd1) == LOCK_C) begin
            good_cnt_d = good_cnt_q + 4'd1;
            state_d    = ST_LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
        ST_LOCKED: begin
          err_d = flags_s;
          if (!good_s) begin
            state_d    = ST_MEASURE;
            good_cnt_d = 4'd0;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d    = ST_SEARCH;
          good_cnt_d = 4'd0;
        end
      endcase
    end else if (timeout_s) begin
      state_d    = ST_SEARCH;
      good_cnt_d = 4'd0;
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge vin_clk_i) begin
    if (vin_rst_i) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      data_q      <= 24'd0;
      h_cnt_q     <= 12'd0;
      v_cnt_q     <= 11'd0;
      line_seen_q <= 1'b0;
      hs_pend_q   <= 1'b0;
      h_acc_q     <= 1'b0;
      hs_acc_q    <= 1'b0;
      frame_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 3'd0;
      state_q     <= ST_SEARCH;
      good_cnt_q  <= 4'd0;
      to_cnt_q    <= 24'd0;
    end else begin
      hs_q        <= vin_hs_i;
      vs_q        <= vin_vs_i;
      de_q        <= vin_de_i;
      data_q      <= vin_data_i;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_seen_q <= line_seen_d;
      hs_pend_q   <= hs_pend_d;
      h_acc_q     <= h_acc_d;
      hs_acc_q    <= hs_acc_d;
      frame_q     <= frame_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign vout_hs_o   = hs_q;
  assign vout_vs_o   = vs_q;
  assign vout_de_o   = de_q;
  assign vout_data_o = data_q;
  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign frame_o     = frame_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_vin_timing_mon.sv
// Directed bench for vin_timing_mon using a reduced raster: 24-clock lines, 16 active
// pixels, HS at 20, 8 active lines, lock after 2 good frames, timeout 1000 clocks.
module tb_vin_timing_mon;

  logic        clk = 1'b0;
  logic        vin_rst;
  logic        vin_hs, vin_vs, vin_de;
  logic [23:0] vin_data;
  logic        vout_hs, vout_vs, vout_de;
  logic [23:0] vout_data;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        frame, locked;
  logic [2:0]  err;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int vs_cyc = 0;
  bit chk_en = 1'b1;
  logic       obs_frame, obs_locked, obs_pre_locked;
  logic [2:0] obs_err;

  vin_timing_mon #(
    .H_WIDTH(16), .H_START(20), .H_TOTAL(24), .V_HEIGHT(8),
    .LOCK_FRAMES(2), .TIMEOUT(1000)
  ) dut (
    .vin_clk_i(clk), .vin_rst_i(vin_rst),
    .vin_hs_i(vin_hs), .vin_vs_i(vin_vs), .vin_de_i(vin_de), .vin_data_i(vin_data),
    .vout_hs_o(vout_hs), .vout_vs_o(vout_vs), .vout_de_o(vout_de), .vout_data_o(vout_data),
    .h_cnt_o(h_cnt), .v_cnt_o(v_cnt), .frame_o(frame), .locked_o(locked), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic d, input logic [23:0] px,
                       input logic r);
    vin_rst  = r;
    vin_hs   = h;
    vin_vs   = v;
    vin_de   = d;
    vin_data = px;
    @(posedge clk);
    #1;
    cyc++;
    if (chk_en && !r) begin
      chk("passthru", {37'd0, vout_hs, vout_vs, vout_de, vout_data}, {37'd0, h, v, d, px});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vout"}, {37'd0, vout_hs, vout_vs, vout_de, vout_data}, 64'd0);
    chk({tag, "_cnt"}, {41'd0, h_cnt, v_cnt}, 64'd0);
    chk({tag, "_stat"}, {58'd0, frame, locked, err}, 64'd0);
  endtask

  task automatic send_line(input bit active, input bit vs_l, input int width, input int hs_pos,
                           input int line_no, input bit rst_here);
    logic h, d, r;
    logic [23:0] px;
    for (int i = 0; i < 24; i++) begin
      d  = active && (i < width);
      h  = (i == hs_pos) || (i == hs_pos + 1);
      r  = rst_here && (i == 5);
      px = {8'(line_no), 8'(i), 8'(cyc)};
      if (vs_l && i == 0) obs_pre_locked = locked;
      drive(h, vs_l, d, px, r);
      if (vs_l && i == 0) begin
        obs_frame  = frame;
        obs_locked = locked;
        obs_err    = err;
        vs_cyc     = cyc;
      end
      if (r) begin
        chk_all_zero("rst_mid");
      end else if (chk_en) begin
        chk("frame_o", {63'd0, frame}, {63'd0, (vs_l && i == 0)});
        if (active) begin
          chk("h_cnt", {52'd0, h_cnt}, 64'(i));
          chk("v_cnt", {53'd0, v_cnt}, 64'(line_no));
        end
      end
    end
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_w,
                            input int hs_pos, input int rst_line);
    send_line(1'b0, 1'b1, 0, hs_pos, 0, 1'b0);
    send_line(1'b0, 1'b0, 0, hs_pos, 0, 1'b0);
    for (int k = 0; k < nlines; k++) begin
      send_line(1'b1, 1'b0, (k == bad_line) ? bad_w : 16, hs_pos, k, (k == rst_line));
    end
    send_line(1'b0, 1'b0, 0, hs_pos, 0, 1'b0);
  endtask

  task automatic frame_chk(input string tag, input logic exp_locked, input logic [2:0] exp_err);
    chk({tag, "_frame"}, {63'd0, obs_frame}, 64'd1);
    chk({tag, "_locked"}, {63'd0, obs_locked}, {63'd0, exp_locked});
    chk({tag, "_err"}, {61'd0, obs_err}, {61'd0, exp_err});
  endtask

  initial begin
    chk_en = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    chk_all_zero("reset");
    chk_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h123456, 1'b0);

    // conforming frames: lock on the 3rd VS rise, together with frame_o
    send_frame(8, -1, 16, 20, -1); frame_chk("f1", 1'b0, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f2", 1'b0, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f3", 1'b1, 3'b000);
    chk("f3_pre_locked", {63'd0, obs_pre_locked}, 64'd0);
    send_frame(8, -1, 16, 20, -1); frame_chk("f4", 1'b1, 3'b000);
    // one 17-pixel line
    send_frame(8, 3, 17, 20, -1);  frame_chk("f5", 1'b1, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f6", 1'b0, 3'b010);
    send_frame(8, -1, 16, 20, -1); frame_chk("f7", 1'b0, 3'b000);
    // 7-line frame, then HS shifted to 21
    send_frame(7, -1, 16, 20, -1); frame_chk("f8", 1'b1, 3'b000);
    send_frame(8, -1, 16, 21, -1); frame_chk("f9", 1'b0, 3'b001);
    send_frame(8, -1, 16, 20, -1); frame_chk("f10", 1'b0, 3'b100);
    send_frame(8, -1, 16, 20, -1); frame_chk("f11", 1'b0, 3'b000);
    // locked, then a short frame that is never closed before the timeout
    send_frame(7, -1, 16, 20, -1); frame_chk("f12", 1'b1, 3'b000);
    while (cyc - vs_cyc < 990) drive(1'b0, 1'b0, 1'b0, 24'(cyc), 1'b0);
    chk("pre_timeout_locked", {63'd0, locked}, 64'd1);
    while (cyc - vs_cyc < 1010) drive(1'b0, 1'b0, 1'b0, 24'(cyc), 1'b0);
    chk("timeout_locked", {63'd0, locked}, 64'd0);
    chk("timeout_err", {61'd0, err}, 64'd0);
    // VS rise out of SEARCH must not report the partial 7-line frame
    send_frame(8, -1, 16, 20, -1); frame_chk("f13", 1'b0, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f14", 1'b0, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f15", 1'b1, 3'b000);
    // reset pulsed mid-line while locked
    chk_en = 1'b0;
    send_frame(8, -1, 16, 20, 2);  frame_chk("f16", 1'b1, 3'b000);
    chk_en = 1'b1;
    send_frame(8, -1, 16, 20, -1); frame_chk("f17", 1'b0, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f18", 1'b0, 3'b000);
    send_frame(8, -1, 16, 20, -1); frame_chk("f19", 1'b1, 3'b000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
